// File: rtl/tmon_cmd_if.sv
// Command/response channel between a temperature-monitor host and its responder.
// The host uses the master modport and the responder uses the slave modport.
interface tmon_cmd_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_op;
  logic [7:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_op, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_op, rsp_data
  );
endinterface

// File: rtl/tmon_cmd_responder.sv
// Temperature-monitor responder: executes TMOB_OP commands, samples the sensor and tracks statistics.
// Define TMON_ALARM_LATCH_EN to make the first non-OK status sticky until a RESET op or rst.
module tmon_cmd_responder #(
  parameter int unsigned PRESCALE   = 16,
  parameter logic [7:0]  PERIOD_RST = 8'd10,
  parameter logic [7:0]  HIGH_RST   = 8'd80,
  parameter logic [7:0]  LOW_RST    = 8'd10,
  parameter int unsigned AVG_LOG2   = 3
) (
  input  logic       clk,
  input  logic       rst,
  tmon_cmd_if.slave  cmd_bus,
  input  logic       i_sensor_valid,
  input  logic [7:0] i_sensor_data,
  output logic       o_sample_req,
  output logic [1:0] o_status
);

  localparam int unsigned PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DEPTH = 2 ** AVG_LOG2;
  localparam int unsigned SW    = 8 + AVG_LOG2;

  localparam logic [3:0] OP_RESET = 4'h0;
  localparam logic [3:0] OP_FRQ   = 4'h1;
  localparam logic [3:0] OP_HIGH  = 4'h2;
  localparam logic [3:0] OP_LOW   = 4'h3;
  localparam logic [3:0] OP_NOOP  = 4'h8;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  typedef enum logic [1:0] {C_IDLE, C_EXEC, C_RESP} cmd_state_t;
  typedef enum logic       {S_IDLE, S_WAIT} smp_state_t;

  cmd_state_t    r_cstate, w_cnext;
  smp_state_t    r_sstate, w_snext;
  logic [3:0]    r_op;
  logic [7:0]    r_arg;
  logic [3:0]    r_rsp_op;
  logic [7:0]    r_rsp_data;
  logic [7:0]    r_period, r_high, r_low;
  logic [PW-1:0] r_pre;
  logic [7:0]    r_pcnt;
  logic          r_sample_req;
  logic [7:0]    r_max, r_min, r_last;
  logic [7:0]    r_ring [DEPTH];
  logic [SW-1:0] r_sum;
  logic [AVG_LOG2-1:0] r_wp;
  logic [1:0]    r_status, r_stat_new;
  logic          r_stat_pend;

  logic       w_accept, w_exec, w_do_reset, w_do_frq, w_do_high, w_do_low, w_do_out;
  logic       w_pre_tc, w_per_tc, w_tc, w_req_c, w_capture;
  logic [7:0] w_avg, w_out_val;
  logic [1:0] w_cmp;

  assign w_accept   = cmd_bus.cmd_valid && (r_cstate == C_IDLE);
  assign w_exec     = (r_cstate == C_EXEC) && !r_op[3];
  assign w_do_reset = w_exec && (r_op == OP_RESET);
  assign w_do_frq   = w_exec && (r_op == OP_FRQ);
  assign w_do_high  = w_exec && (r_op == OP_HIGH);
  assign w_do_low   = w_exec && (r_op == OP_LOW);
  assign w_do_out   = w_exec && r_op[2];

  assign w_avg = r_sum[SW-1 -: 8];
  assign w_cmp = (i_sensor_data > r_high) ? ST_HIGH :
                 (i_sensor_data < r_low)  ? ST_LOW  : ST_OK;

  // Command FSM next state
  always_comb begin
    w_cnext = r_cstate;
    case (r_cstate)
      C_IDLE:  if (cmd_bus.cmd_valid) w_cnext = C_EXEC;
      C_EXEC:  w_cnext = w_do_out ? C_RESP : C_IDLE;
      C_RESP:  if (cmd_bus.rsp_ready) w_cnext = C_IDLE;
      default: w_cnext = C_IDLE;
    endcase
  end

  always_comb begin
    w_out_val = r_max;
    case (r_op[1:0])
      2'd0:    w_out_val = r_max;
      2'd1:    w_out_val = r_min;
      2'd2:    w_out_val = r_last;
      default: w_out_val = w_avg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cstate   <= C_IDLE;
      r_op       <= OP_NOOP;
      r_arg      <= '0;
      r_rsp_op   <= OP_NOOP;
      r_rsp_data <= '0;
    end else begin
      r_cstate <= w_cnext;
      if (w_accept) begin
        r_op  <= cmd_bus.cmd_op;
        r_arg <= cmd_bus.cmd_data;
      end
      if (w_do_out) begin
        r_rsp_op   <= r_op;
        r_rsp_data <= w_out_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period <= PERIOD_RST;
      r_high   <= HIGH_RST;
      r_low    <= LOW_RST;
    end else begin
      if (w_do_frq)  r_period <= r_arg;
      if (w_do_high) r_high   <= r_arg;
      if (w_do_low)  r_low    <= r_arg;
    end
  end

  // Sample-rate timebase: PRESCALE clocks per unit, r_period units per request
  assign w_pre_tc = (r_pre == PW'(PRESCALE - 1));
  assign w_per_tc = (r_pcnt == (r_period - 8'd1));
  assign w_tc     = (r_period != 8'd0) && w_pre_tc && w_per_tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre  <= '0;
      r_pcnt <= '0;
    end else if (w_do_frq || (r_period == 8'd0)) begin
      r_pre  <= '0;
      r_pcnt <= '0;
    end else if (w_pre_tc) begin
      r_pre  <= '0;
      r_pcnt <= w_per_tc ? 8'd0 : (r_pcnt + 8'd1);
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // Sampler FSM; a terminal count while waiting is dropped
  always_comb begin
    w_snext = r_sstate;
    w_req_c = 1'b0;
    case (r_sstate)
      S_IDLE: if (w_tc) begin
        w_snext = S_WAIT;
        w_req_c = 1'b1;
      end
      S_WAIT:  if (i_sensor_valid) w_snext = S_IDLE;
      default: w_snext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sstate     <= S_IDLE;
      r_sample_req <= 1'b0;
    end else begin
      r_sstate     <= w_snext;
      r_sample_req <= w_req_c;
    end
  end

  // A RESET op in EXEC discards a sample arriving in the same cycle
  assign w_capture = (r_sstate == S_WAIT) && i_sensor_valid && !w_do_reset;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max  <= 8'h00;
      r_min  <= 8'hFF;
      r_last <= 8'h00;
      r_sum  <= '0;
      r_wp   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_ring[i] <= 8'h00;
    end else if (w_do_reset) begin
      r_max  <= 8'h00;
      r_min  <= 8'hFF;
      r_last <= 8'h00;
      r_sum  <= '0;
      r_wp   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_ring[i] <= 8'h00;
    end else if (w_capture) begin
      r_last <= i_sensor_data;
      if (i_sensor_data > r_max) r_max <= i_sensor_data;
      if (i_sensor_data < r_min) r_min <= i_sensor_data;
      r_ring[r_wp] <= i_sensor_data;
      r_sum        <= r_sum - SW'(r_ring[r_wp]) + SW'(i_sensor_data);
      r_wp         <= r_wp + AVG_LOG2'(1);
    end
  end

  // Compare uses thresholds at capture time; status lands one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status    <= ST_OK;
      r_stat_new  <= ST_OK;
      r_stat_pend <= 1'b0;
    end else if (w_do_reset) begin
      r_status    <= ST_OK;
      r_stat_new  <= ST_OK;
      r_stat_pend <= 1'b0;
    end else begin
      r_stat_pend <= w_capture;
      if (w_capture) r_stat_new <= w_cmp;
      if (r_stat_pend) begin
`ifdef TMON_ALARM_LATCH_EN
        if (r_status == ST_OK) r_status <= r_stat_new;
`else
        r_status <= r_stat_new;
`endif
      end
    end
  end

  assign cmd_bus.cmd_ready = (r_cstate == C_IDLE);
  assign cmd_bus.rsp_valid = (r_cstate == C_RESP);
  assign cmd_bus.rsp_op    = r_rsp_op;
  assign cmd_bus.rsp_data  = r_rsp_data;
  assign o_sample_req      = r_sample_req;
  assign o_status          = r_status;

endmodule

// File: tb/tb_tmon_cmd_responder.sv
// Directed self-checking bench for tmon_cmd_responder (honours TMON_ALARM_LATCH_EN when defined).
module tb_tmon_cmd_responder;

  localparam logic [3:0] OP_RESET = 4'h0;
  localparam logic [3:0] OP_FRQ   = 4'h1;
  localparam logic [3:0] OP_HIGH  = 4'h2;
  localparam logic [3:0] OP_MAX   = 4'h4;
  localparam logic [3:0] OP_MIN   = 4'h5;
  localparam logic [3:0] OP_ADDR  = 4'h6;
  localparam logic [3:0] OP_AVG   = 4'h7;
  localparam logic [3:0] OP_NOOP  = 4'h8;
  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_LOW   = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       sensor_valid;
  logic [7:0] sensor_data;
  logic       sample_req;
  logic [1:0] status;
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         req_cnt = 0;
  int         t_req = 0;
  int         consumed = 0;
  int         t1, t2;

  always #5 clk = ~clk;

  tmon_cmd_if bus ();

  tmon_cmd_responder dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_bus        (bus),
    .i_sensor_valid (sensor_valid),
    .i_sensor_data  (sensor_data),
    .o_sample_req   (sample_req),
    .o_status       (status)
  );

  // Cycle counter and sample-request log
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sample_req) begin
      req_cnt <= req_cnt + 1;
      t_req   <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // All tasks are entered and left on a negedge
  task automatic send_cmd(input logic [3:0] op, input logic [7:0] d);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", 32'(n < 50), 1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOOP;
  endtask

  task automatic read_cmd(input logic [3:0] op, input logic [7:0] exp, input string tag);
    int lat = 1;
    send_cmd(op, 8'h00);
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 2);
    check({tag, "_op"}, bus.rsp_op, op);
    check(tag, bus.rsp_data, exp);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_req(output int t);
    int n = 0;
    while (req_cnt == consumed && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("sample_req_seen", 32'(n < 2000), 1);
    consumed++;
    t = t_req;
  endtask

  task automatic feed(input logic [7:0] v, output int t);
    wait_req(t);
    sensor_valid = 1'b1;
    sensor_data  = v;
    @(negedge clk);
    sensor_valid = 1'b0;
  endtask

  task automatic check_status(input logic [1:0] exp, input string tag);
    repeat (2) @(negedge clk);
    check(tag, status, exp);
  endtask

  initial begin
    rst           = 1'b1;
    sensor_valid  = 1'b0;
    sensor_data   = 8'h00;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOOP;
    bus.cmd_data  = 8'h00;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_op", bus.rsp_op, OP_NOOP);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_sample_req", sample_req, 0);
    check("rst_status", status, ST_OK);

    // Default period 10 x 16 clk
    feed(8'd20, t1);
    feed(8'd50, t2);
    check("period_160", t2 - t1, 160);
    feed(8'd30, t1);
    check_status(ST_OK, "status_ok");
    read_cmd(OP_MAX, 8'd50, "max_50");
    read_cmd(OP_MIN, 8'd20, "min_20");
    read_cmd(OP_ADDR, 8'd30, "last_30");
    read_cmd(OP_AVG, 8'd12, "avg_12");

    // Threshold compare, strict at equality
    send_cmd(OP_HIGH, 8'd40);
    feed(8'd41, t1);
    check_status(ST_HIGH, "status_41_high");
    feed(8'd40, t1);
`ifdef TMON_ALARM_LATCH_EN
    check_status(ST_HIGH, "status_40_latched");
    feed(8'd5, t1);
    check_status(ST_HIGH, "status_5_latched");
`else
    check_status(ST_OK, "status_40_ok");
    feed(8'd5, t1);
    check_status(ST_LOW, "status_5_low");
`endif

    // Faster period: 2 x 16 clk
    send_cmd(OP_FRQ, 8'd2);
    feed(8'd9, t1);
    feed(8'd9, t2);
    check("period_32", t2 - t1, 32);

    // Response held under back-pressure
    begin
      int lat = 1;
      send_cmd(OP_MAX, 8'h00);
      while (!bus.rsp_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check("hold_lat", lat, 2);
      for (int i = 0; i < 5; i++) begin
        check("hold_valid", bus.rsp_valid, 1);
        check("hold_data", bus.rsp_data, 50);
        check("hold_cmd_ready", bus.cmd_ready, 0);
        @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check("hold_done_valid", bus.rsp_valid, 0);
      check("hold_done_ready", bus.cmd_ready, 1);
    end

    // RESET op clears stats and status
    send_cmd(OP_RESET, 8'h00);
    check_status(ST_OK, "reset_status");
    read_cmd(OP_MAX, 8'h00, "reset_max");
    read_cmd(OP_MIN, 8'hFF, "reset_min");

    // Ring wrap: 9 x 8 then 80 -> (7*8+80)>>3
    for (int i = 0; i < 9; i++) feed(8'd8, t1);
    feed(8'd80, t1);
`ifdef TMON_ALARM_LATCH_EN
    check_status(ST_LOW, "status_80_latched");
`else
    check_status(ST_HIGH, "status_80_high");
`endif
    read_cmd(OP_AVG, 8'd17, "avg_17");
    read_cmd(OP_MAX, 8'd80, "max_80");
    read_cmd(OP_MIN, 8'd8, "min_8");
    read_cmd(OP_ADDR, 8'd80, "last_80");

    // RESET op in EXEC while sample 99 is captured
    wait_req(t1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_RESET;
    check("coll_ready", bus.cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOOP;
    sensor_valid  = 1'b1;
    sensor_data   = 8'd99;
    @(posedge clk);
    @(negedge clk);
    sensor_valid = 1'b0;
    check_status(ST_OK, "coll_status");
    read_cmd(OP_MAX, 8'h00, "coll_max");
    read_cmd(OP_MIN, 8'hFF, "coll_min");
    read_cmd(OP_ADDR, 8'h00, "coll_last");
    read_cmd(OP_AVG, 8'h00, "coll_avg");
    feed(8'd55, t1);
    read_cmd(OP_ADDR, 8'd55, "after_coll_last");

    // op[3] set: no response
    send_cmd(4'hD, 8'hAA);
    for (int i = 0; i < 3; i++) begin
      check("noop_no_rsp", bus.rsp_valid, 0);
      @(negedge clk);
    end
    check("noop_ready", bus.cmd_ready, 1);

    // rst during a pending response
    send_cmd(OP_MAX, 8'h00);
    @(negedge clk);
    check("midrst_pre_valid", bus.rsp_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", bus.rsp_valid, 0);
    check("midrst_data", bus.rsp_data, 0);
    check("midrst_op", bus.rsp_op, OP_NOOP);
    check("midrst_ready", bus.cmd_ready, 1);
    check("midrst_status", status, ST_OK);
    rst = 1'b0;
    @(negedge clk);
    read_cmd(OP_MIN, 8'hFF, "midrst_min");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
